rstmgr_pwr_rsp: RTL and testbench



---
 rtl/pwrmgr_pkg.sv | 25 ++
 rtl/rstmgr_pkg.sv | 20 ++
 rtl/rstmgr_rst_stretch.sv | 66 ++++++
 rtl/rstmgr_pwr_rsp.sv | 89 ++++++++
 tb/tb_rstmgr_pwr_rsp.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pwrmgr_pkg.sv
// Types shared with pwrmgr for the pwr_rst request/response interface.
package pwrmgr_pkg;

    localparam int PowerDomains = 2;
    localparam int NumRstReqs   = 2;

    typedef enum logic [1:0] {
        ResetNone   = 2'd0,
        LowPwrEntry = 2'd1,
        HwReq       = 2'd2
    } reset_cause_e;

    typedef struct packed {
        logic [PowerDomains-1:0] rst_lc_req;
        logic [PowerDomains-1:0] rst_sys_req;
        reset_cause_e            reset_cause;
        logic [NumRstReqs-1:0]   rstreqs;
    } pwr_rst_req_t;

    typedef struct packed {
        logic [PowerDomains-1:0] rst_lc_src_n;
        logic [PowerDomains-1:0] rst_sys_src_n;
    } pwr_rst_rsp_t;

endpackage

// File: rtl/rstmgr_pkg.sv
// Reset-manager local types: tree FSM states and reset-info vector layout.
package rstmgr_pkg;

    typedef enum logic [1:0] {
        StAssert  = 2'd0,
        StStretch = 2'd1,
        StRelease = 2'd2
    } tree_st_e;

    localparam int InfoWidth     = pwrmgr_pkg::NumRstReqs + 2;
    localparam int InfoPorIdx    = 0;
    localparam int InfoLowPwrIdx = 1;
    localparam int InfoHwReqLsb  = 2;

    // Counter must be able to hold StretchCycles itself so it can saturate there.
    function automatic int cnt_width(input int stretch);
        return $clog2(stretch + 1);
    endfunction

endpackage

// File: rtl/rstmgr_rst_stretch.sv
// One reset tree: holds its active-low output asserted while requested and for
// StretchCycles afterwards, releasing only when release_en_i allows it.
module rstmgr_rst_stretch
    import rstmgr_pkg::*;
#(
    parameter int StretchCycles = 32
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req_i,
    input  logic release_en_i,
    output logic rst_no
);

    localparam int              CntW    = cnt_width(StretchCycles);
    localparam logic [CntW-1:0] CntLast = CntW'(StretchCycles - 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(StretchCycles);

    tree_st_e        r_state;
    logic [CntW-1:0] r_cnt;
    logic            r_out;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= StStretch;
            r_cnt   <= '0;
            r_out   <= 1'b0;
        end else begin
            case (r_state)
                StAssert: begin
                    r_out <= 1'b0;
                    if (!req_i) begin
                        r_state <= StStretch;
                        r_cnt   <= '0;
                    end
                end
                StStretch: begin
                    if (req_i) begin
                        r_state <= StAssert;
                        r_cnt   <= '0;
                    end else if (r_cnt >= CntLast && release_en_i) begin
                        // >= because a blocked release keeps counting up to saturation
                        r_state <= StRelease;
                        r_out   <= 1'b1;
                    end else if (r_cnt != CntMax) begin
                        r_cnt <= r_cnt + CntW'(1);
                    end
                end
                StRelease: begin
                    if (req_i) begin
                        r_state <= StAssert;
                        r_out   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= StStretch;
                    r_cnt   <= '0;
                    r_out   <= 1'b0;
                end
            endcase
        end
    end

    assign rst_no = r_out;

endmodule

// File: rtl/rstmgr_pwr_rsp.sv
// Reset-manager responder for pwrmgr reset requests: per-domain lc/sys stretch
// trees, acks back to pwrmgr, and sticky reset-cause capture.
module rstmgr_pwr_rsp
    import pwrmgr_pkg::*;
    import rstmgr_pkg::*;
#(
    parameter int StretchCycles = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  pwr_rst_req_t            pwr_rst_i,
    output pwr_rst_rsp_t            pwr_rst_o,
    output logic [PowerDomains-1:0] rst_lc_no,
    output logic [PowerDomains-1:0] rst_sys_no,
    output logic [InfoWidth-1:0]    info_o,
    input  logic                    info_clr_i
);

    logic [PowerDomains-1:0] w_lc_out;
    logic [PowerDomains-1:0] w_sys_out;
    logic [PowerDomains-1:0] w_sys_req;

    genvar gi;
    generate
        for (gi = 0; gi < PowerDomains; gi++) begin : g_dom
            // An lc request pulls sys down in the same cycle; sys may only let go once lc has.
            assign w_sys_req[gi] = pwr_rst_i.rst_sys_req[gi] | pwr_rst_i.rst_lc_req[gi];

            rstmgr_rst_stretch #(
                .StretchCycles (StretchCycles)
            ) u_lc (
                .clk_i        (clk_i),
                .rst_ni       (rst_ni),
                .req_i        (pwr_rst_i.rst_lc_req[gi]),
                .release_en_i (1'b1),
                .rst_no       (w_lc_out[gi])
            );

            rstmgr_rst_stretch #(
                .StretchCycles (StretchCycles)
            ) u_sys (
                .clk_i        (clk_i),
                .rst_ni       (rst_ni),
                .req_i        (w_sys_req[gi]),
                .release_en_i (w_lc_out[gi]),
                .rst_no       (w_sys_out[gi])
            );
        end
    endgenerate

    assign rst_lc_no               = w_lc_out;
    assign rst_sys_no              = w_sys_out;
    assign pwr_rst_o.rst_lc_src_n  = w_lc_out;
    assign pwr_rst_o.rst_sys_src_n = w_sys_out;

    logic                 r_lc0_prev;
    logic [InfoWidth-1:0] r_info;
    logic                 w_lc0_rise;
    logic [InfoWidth-1:0] w_info_next;

    assign w_lc0_rise = pwr_rst_i.rst_lc_req[0] & ~r_lc0_prev;

    // Clear first, then OR in this cycle's capture so a coincident set survives.
    always_comb begin
        w_info_next = info_clr_i ? '0 : r_info;
        if (w_lc0_rise) begin
            if (pwr_rst_i.reset_cause == LowPwrEntry) begin
                w_info_next[InfoLowPwrIdx] = 1'b1;
            end
            if (pwr_rst_i.reset_cause == HwReq) begin
                w_info_next[InfoWidth-1:InfoHwReqLsb] =
                    w_info_next[InfoWidth-1:InfoHwReqLsb] | pwr_rst_i.rstreqs;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lc0_prev <= 1'b0;
            r_info     <= InfoWidth'(1 << InfoPorIdx);
        end else begin
            r_lc0_prev <= pwr_rst_i.rst_lc_req[0];
            r_info     <= w_info_next;
        end
    end

    assign info_o = r_info;

endmodule

// File: tb/tb_rstmgr_pwr_rsp.sv
// Self-checking bench for rstmgr_pwr_rsp: directed scenarios plus a randomized
// run against a time-since-last-request reference model.
module tb_rstmgr_pwr_rsp;
    import pwrmgr_pkg::*;
    import rstmgr_pkg::*;

    localparam int SC = 32;

    logic         clk;
    logic         rst_n;
    pwr_rst_req_t req_s;
    pwr_rst_rsp_t rsp_s;
    logic [1:0]   lc_no;
    logic [1:0]   sys_no;
    logic [3:0]   info;
    logic         info_clr;

    int n_checks = 0;
    int n_err    = 0;

    rstmgr_pwr_rsp #(.StretchCycles(SC)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .pwr_rst_i  (req_s),
        .pwr_rst_o  (rsp_s),
        .rst_lc_no  (lc_no),
        .rst_sys_no (sys_no),
        .info_o     (info),
        .info_clr_i (info_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a tree output is high once SC+1 consecutive quiet samples
    // have elapsed since its last request; sys also needs lc high the cycle before.
    int         q_lc [2];
    int         q_sys[2];
    logic [1:0] m_lc;
    logic [1:0] m_sys;
    logic [3:0] m_info;
    logic       m_prev0;

    function automatic int next_q(input int q, input logic r);
        if (r) return 0;
        return (q >= 1000) ? 1000 : q + 1;
    endfunction

    function automatic logic [3:0] info_step(input logic [3:0] cur, input logic clr,
                                             input logic rise, input reset_cause_e c,
                                             input logic [1:0] hw);
        logic [3:0] n;
        n = clr ? 4'b0000 : cur;
        if (rise && c == LowPwrEntry) n[1] = 1'b1;
        if (rise && c == HwReq) n[3:2] = n[3:2] | hw;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                q_lc[d]  <= 1;
                q_sys[d] <= 1;
            end
            m_lc    <= 2'b00;
            m_sys   <= 2'b00;
            m_info  <= 4'b0001;
            m_prev0 <= 1'b0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                q_lc[d]  <= next_q(q_lc[d], req_s.rst_lc_req[d]);
                q_sys[d] <= next_q(q_sys[d], req_s.rst_sys_req[d] | req_s.rst_lc_req[d]);
                m_lc[d]  <= (next_q(q_lc[d], req_s.rst_lc_req[d]) >= SC + 1);
                m_sys[d] <= (next_q(q_sys[d], req_s.rst_sys_req[d] | req_s.rst_lc_req[d]) >= SC + 1)
                            && m_lc[d];
            end
            m_prev0 <= req_s.rst_lc_req[0];
            m_info  <= info_step(m_info, info_clr, req_s.rst_lc_req[0] & ~m_prev0,
                                 req_s.reset_cause, req_s.rstreqs);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [1:0] e_lc, e_sys;
        rst_n    = 1'b0;
        req_s    = '0;
        info_clr = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({lc_no, sys_no, rsp_s} !== 8'h00) begin
            n_err++;
            $display("FAIL reset_outputs got=%b required=%b", {lc_no, sys_no, rsp_s}, 8'h00);
        end
        n_checks++;
        if (info !== 4'b0001) begin
            n_err++;
            $display("FAIL reset_info got=%b required=%b", info, 4'b0001);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 34; k++) begin
            tick();
            e_lc  = (k >= SC)     ? 2'b11 : 2'b00;
            e_sys = (k >= SC + 1) ? 2'b11 : 2'b00;
            n_checks++;
            if (lc_no !== e_lc || rsp_s.rst_lc_src_n !== e_lc) begin
                n_err++;
                $display("FAIL reset_lc_release cyc=%0d got=%b/%b required=%b", k, lc_no, rsp_s.rst_lc_src_n, e_lc);
            end
            n_checks++;
            if (sys_no !== e_sys || rsp_s.rst_sys_src_n !== e_sys) begin
                n_err++;
                $display("FAIL reset_sys_release cyc=%0d got=%b/%b required=%b", k, sys_no, rsp_s.rst_sys_src_n, e_sys);
            end
        end
    endtask

    task automatic test_lc_pulse;
        req_s.rst_lc_req[1] = 1'b1;
        tick();
        req_s.rst_lc_req[1] = 1'b0;
        n_checks++;
        if (lc_no !== 2'b01 || sys_no !== 2'b01) begin
            n_err++;
            $display("FAIL lc_pulse_assert got lc=%b sys=%b required lc=01 sys=01", lc_no, sys_no);
        end
        for (int k = 1; k <= 34; k++) begin
            tick();
            n_checks++;
            if (lc_no[1] !== (k >= SC + 1) || rsp_s.rst_lc_src_n[1] !== (k >= SC + 1)) begin
                n_err++;
                $display("FAIL lc_pulse_lc1 cyc=%0d got=%b required=%b", k, lc_no[1], (k >= SC + 1));
            end
            n_checks++;
            if (sys_no[1] !== (k >= SC + 2) || rsp_s.rst_sys_src_n[1] !== (k >= SC + 2)) begin
                n_err++;
                $display("FAIL lc_pulse_sys1 cyc=%0d got=%b required=%b", k, sys_no[1], (k >= SC + 2));
            end
            n_checks++;
            if (lc_no[0] !== 1'b1 || sys_no[0] !== 1'b1) begin
                n_err++;
                $display("FAIL lc_pulse_dom0 cyc=%0d got lc=%b sys=%b required 1/1", k, lc_no[0], sys_no[0]);
            end
        end
    endtask

    task automatic test_restretch;
        req_s.rst_lc_req[0] = 1'b1;
        tick();
        req_s.rst_lc_req[0] = 1'b0;
        repeat (21) tick();
        n_checks++;
        if (lc_no[0] !== 1'b0) begin
            n_err++;
            $display("FAIL restretch_mid got=%b required=0", lc_no[0]);
        end
        req_s.rst_lc_req[0] = 1'b1;
        tick();
        req_s.rst_lc_req[0] = 1'b0;
        for (int k = 1; k <= 34; k++) begin
            tick();
            n_checks++;
            if (lc_no[0] !== (k >= SC + 1)) begin
                n_err++;
                $display("FAIL restretch_lc0 cyc=%0d got=%b required=%b", k, lc_no[0], (k >= SC + 1));
            end
            n_checks++;
            if (sys_no[0] !== (k >= SC + 2)) begin
                n_err++;
                $display("FAIL restretch_sys0 cyc=%0d got=%b required=%b", k, sys_no[0], (k >= SC + 2));
            end
        end
    endtask

    task automatic test_cause_hwreq;
        req_s.rst_lc_req[0] = 1'b1;
        req_s.reset_cause   = HwReq;
        req_s.rstreqs       = 2'b10;
        tick();
        n_checks++;
        if (info !== 4'b1001) begin
            n_err++;
            $display("FAIL hwreq_capture got=%b required=%b", info, 4'b1001);
        end
        req_s.rstreqs = 2'b01;
        tick();
        n_checks++;
        if (info !== 4'b1001) begin
            n_err++;
            $display("FAIL hwreq_no_rise got=%b required=%b", info, 4'b1001);
        end
        req_s.rst_lc_req[0] = 1'b0;
        req_s.reset_cause   = ResetNone;
        info_clr            = 1'b1;
        tick();
        info_clr = 1'b0;
        n_checks++;
        if (info !== 4'b0000) begin
            n_err++;
            $display("FAIL info_clear got=%b required=%b", info, 4'b0000);
        end
        tick();
        n_checks++;
        if (info !== 4'b0000) begin
            n_err++;
            $display("FAIL info_clear_hold got=%b required=%b", info, 4'b0000);
        end
    endtask

    task automatic test_clr_collision;
        req_s.rst_lc_req[0] = 1'b1;
        req_s.reset_cause   = HwReq;
        req_s.rstreqs       = 2'b01;
        tick();
        req_s.rst_lc_req[0] = 1'b0;
        n_checks++;
        if (info !== 4'b0100) begin
            n_err++;
            $display("FAIL collision_pre got=%b required=%b", info, 4'b0100);
        end
        tick();
        req_s.rst_lc_req[0] = 1'b1;
        req_s.reset_cause   = LowPwrEntry;
        info_clr            = 1'b1;
        tick();
        info_clr            = 1'b0;
        req_s.rst_lc_req[0] = 1'b0;
        req_s.reset_cause   = ResetNone;
        n_checks++;
        if (info !== 4'b0010) begin
            n_err++;
            $display("FAIL collision_set_wins got=%b required=%b", info, 4'b0010);
        end
    endtask

    task automatic test_async_reset;
        repeat (10) tick();
        n_checks++;
        if (lc_no !== 2'b10 || sys_no !== 2'b10) begin
            n_err++;
            $display("FAIL async_pre got lc=%b sys=%b required 10/10", lc_no, sys_no);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({lc_no, sys_no, rsp_s} !== 8'h00) begin
            n_err++;
            $display("FAIL async_outputs got=%b required=%b", {lc_no, sys_no, rsp_s}, 8'h00);
        end
        n_checks++;
        if (info !== 4'b0001) begin
            n_err++;
            $display("FAIL async_info got=%b required=%b", info, 4'b0001);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 34; k++) begin
            tick();
            n_checks++;
            if (lc_no !== ((k >= SC) ? 2'b11 : 2'b00)) begin
                n_err++;
                $display("FAIL async_rerun_lc cyc=%0d got=%b", k, lc_no);
            end
            n_checks++;
            if (sys_no !== ((k >= SC + 1) ? 2'b11 : 2'b00)) begin
                n_err++;
                $display("FAIL async_rerun_sys cyc=%0d got=%b", k, sys_no);
            end
        end
    endtask

    task automatic test_random;
        for (int c = 0; c < 400; c++) begin
            req_s.rst_lc_req[0]  = ($urandom_range(0, 59) == 0);
            req_s.rst_lc_req[1]  = ($urandom_range(0, 59) == 0);
            req_s.rst_sys_req[0] = ($urandom_range(0, 59) == 0);
            req_s.rst_sys_req[1] = ($urandom_range(0, 59) == 0);
            req_s.reset_cause    = reset_cause_e'($urandom_range(0, 2));
            req_s.rstreqs        = 2'($urandom_range(0, 3));
            info_clr             = ($urandom_range(0, 15) == 0);
            tick();
            n_checks++;
            if (lc_no !== m_lc || rsp_s.rst_lc_src_n !== m_lc) begin
                n_err++;
                $display("FAIL rand_lc cyc=%0d got=%b/%b required=%b", c, lc_no, rsp_s.rst_lc_src_n, m_lc);
            end
            n_checks++;
            if (sys_no !== m_sys || rsp_s.rst_sys_src_n !== m_sys) begin
                n_err++;
                $display("FAIL rand_sys cyc=%0d got=%b/%b required=%b", c, sys_no, rsp_s.rst_sys_src_n, m_sys);
            end
            n_checks++;
            if (info !== m_info) begin
                n_err++;
                $display("FAIL rand_info cyc=%0d got=%b required=%b", c, info, m_info);
            end
        end
        req_s    = '0;
        info_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lc_pulse();
        test_restretch();
        test_cause_hwreq();
        test_clr_collision();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
